// File: rtl/bridge_bus_arbiter.sv
// Two-master arbiter for a shared req/ack slave bus: CPU priority with an m1
// starvation guard (or round-robin), one transaction at a time, timeout abort.
module bridge_bus_arbiter #(
  parameter int CPU_PRIORITY = 1,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_we,
  output logic        m0_gnt,
  output logic        m0_done,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_we,
  output logic        m1_gnt,
  output logic        m1_done,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        sl_req,
  output logic [31:0] sl_addr,
  output logic [31:0] sl_wdata,
  output logic [3:0]  sl_we,
  input  logic        sl_ack,
  input  logic [31:0] sl_rdata,
  output logic        busy
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [3:0]  starve_q, starve_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        m0_gnt_q, m0_gnt_d, m1_gnt_q, m1_gnt_d;
  logic        m0_done_q, m0_done_d, m1_done_q, m1_done_d;
  logic [31:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic        m0_err_q, m0_err_d, m1_err_q, m1_err_d;
  logic        sl_req_q, sl_req_d, busy_q, busy_d;
  logic [31:0] sl_addr_q, sl_addr_d, sl_wdata_q, sl_wdata_d;
  logic [3:0]  sl_we_q, sl_we_d;
  logic        tie_m1, win_m1;

  // last_q = 1 means m1 was granted last, so m0 takes the next round-robin tie
  assign tie_m1 = (CPU_PRIORITY != 0) ? (starve_q == STARVE_MAX) : !last_q;
  assign win_m1 = m1_req && (!m0_req || tie_m1);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    starve_d   = starve_q;
    tmo_d      = tmo_q;
    m0_gnt_d   = 1'b0;
    m1_gnt_d   = 1'b0;
    m0_done_d  = 1'b0;
    m1_done_d  = 1'b0;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    m0_err_d   = m0_err_q;
    m1_err_d   = m1_err_q;
    sl_req_d   = sl_req_q;
    sl_addr_d  = sl_addr_q;
    sl_wdata_d = sl_wdata_q;
    sl_we_d    = sl_we_q;
    busy_d     = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_req || m1_req) begin
          state_d    = ST_WAIT;
          owner_d    = win_m1;
          last_d     = win_m1;
          tmo_d      = 8'd0;
          sl_req_d   = 1'b1;
          busy_d     = 1'b1;
          m0_gnt_d   = !win_m1;
          m1_gnt_d   = win_m1;
          sl_addr_d  = win_m1 ? m1_addr  : m0_addr;
          sl_wdata_d = win_m1 ? m1_wdata : m0_wdata;
          sl_we_d    = win_m1 ? m1_we    : m0_we;
          if (win_m1) begin
            starve_d = 4'd0;
          end else if (m1_req && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 4'd1;
          end
        end
      end
      ST_WAIT: begin
        // an ack on the timeout cycle still completes normally
        if (sl_ack || (tmo_q == TMO_LAST)) begin
          state_d  = ST_IDLE;
          sl_req_d = 1'b0;
          busy_d   = 1'b0;
          tmo_d    = 8'd0;
          if (owner_q) begin
            m1_done_d  = 1'b1;
            m1_rdata_d = sl_ack ? sl_rdata : 32'd0;
            m1_err_d   = !sl_ack;
          end else begin
            m0_done_d  = 1'b1;
            m0_rdata_d = sl_ack ? sl_rdata : 32'd0;
            m0_err_d   = !sl_ack;
          end
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      starve_q   <= 4'd0;
      tmo_q      <= 8'd0;
      m0_gnt_q   <= 1'b0;
      m1_gnt_q   <= 1'b0;
      m0_done_q  <= 1'b0;
      m1_done_q  <= 1'b0;
      m0_rdata_q <= 32'd0;
      m1_rdata_q <= 32'd0;
      m0_err_q   <= 1'b0;
      m1_err_q   <= 1'b0;
      sl_req_q   <= 1'b0;
      sl_addr_q  <= 32'd0;
      sl_wdata_q <= 32'd0;
      sl_we_q    <= 4'd0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      starve_q   <= starve_d;
      tmo_q      <= tmo_d;
      m0_gnt_q   <= m0_gnt_d;
      m1_gnt_q   <= m1_gnt_d;
      m0_done_q  <= m0_done_d;
      m1_done_q  <= m1_done_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
      m0_err_q   <= m0_err_d;
      m1_err_q   <= m1_err_d;
      sl_req_q   <= sl_req_d;
      sl_addr_q  <= sl_addr_d;
      sl_wdata_q <= sl_wdata_d;
      sl_we_q    <= sl_we_d;
      busy_q     <= busy_d;
    end
  end

  assign m0_gnt   = m0_gnt_q;
  assign m1_gnt   = m1_gnt_q;
  assign m0_done  = m0_done_q;
  assign m1_done  = m1_done_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;
  assign m0_err   = m0_err_q;
  assign m1_err   = m1_err_q;
  assign sl_req   = sl_req_q;
  assign sl_addr  = sl_addr_q;
  assign sl_wdata = sl_wdata_q;
  assign sl_we    = sl_we_q;
  assign busy     = busy_q;

endmodule

// File: doc/bridge_bus_arbiter.md
Name: bridge_bus_arbiter

Overview:
- Arbitrates one shared data-memory/device bus between two masters: m0 = CPU data port (the BrAddr/BrWData/BrWE/BrRData side of the CPU top) and m1 = a secondary master (DMA/debug).
- Accepts one transaction at a time. Forwards it to a slave that uses a req/ack handshake with variable latency, then returns read data to the winning master.
- Provides CPU priority with a starvation guard for m1, plus a timeout that aborts a hung slave access with an error response.

Parameters:
- CPU_PRIORITY, 1, 1 = m0 wins ties subject to the starvation guard; 0 = round-robin (last-granted loses ties).
- STARVE_LIMIT, 4, number of consecutive arbitration losses by a requesting m1 after which m1 is forced to win (CPU_PRIORITY=1 only); range 1..15.
- TIMEOUT, 16, number of WAIT cycles without sl_ack before abort; range 2..255.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- m0_req  input  1  CPU request; addr/wdata/we held stable until m0_gnt
- m0_addr  input  32  CPU byte address
- m0_wdata  input  32  CPU write data
- m0_we  input  4  CPU byte write enables; 0 = read
- m0_gnt  output  1  one-cycle pulse: request accepted
- m0_done  output  1  one-cycle pulse: response valid
- m0_rdata  output  32  read data, valid with m0_done
- m0_err  output  1  timeout flag, valid with m0_done
- m1_req, m1_addr, m1_wdata, m1_we, m1_gnt, m1_done, m1_rdata, m1_err  same as m0_* for master 1
- sl_req  output  1  slave request, held high through WAIT
- sl_addr  output  32  latched address
- sl_wdata  output  32  latched write data
- sl_we  output  4  latched byte enables
- sl_ack  input  1  slave completion, sampled only in WAIT
- sl_rdata  input  32  slave read data, valid with sl_ack
- busy  output  1  high in WAIT

Behaviour:
- FSM states: IDLE, WAIT. All outputs are registered.
- Reset (reset=0, asynchronous):
  - state=IDLE; every output =0, including rdata buses.
  - Round-robin pointer = m1, so m0 wins the first tie.
  - Starvation counter =0 and timeout counter =0.
  - Reset while in WAIT abandons the transaction: no done pulse, and the slave sees sl_req drop immediately.
- IDLE, one or more req high at an edge:
  - Select a winner and latch its addr/wdata/we into sl_*.
  - Next cycle: state=WAIT, sl_req=1, winner gnt=1 for exactly that cycle.
- IDLE, no req: stay in IDLE with all strobes low.
- Arbitration with CPU_PRIORITY=1:
  - A single requester wins.
  - On a tie, m0 wins unless starve_cnt==STARVE_LIMIT, in which case m1 wins.
  - starve_cnt increments when m1 requests and loses; it resets to 0 when m1 is granted (saturates at STARVE_LIMIT).
- Arbitration with CPU_PRIORITY=0: on a tie, the master not granted last wins; the pointer updates on every grant.
- WAIT:
  - The timeout counter increments each cycle.
  - sl_ack=1 at an edge: next cycle state=IDLE, sl_req=0, winner done=1, winner rdata=sl_rdata (writes also capture sl_rdata), err=0.
  - No ack and counter reaches TIMEOUT: next cycle state=IDLE, done=1, rdata=0, err=1, sl_req=0.
  - If ack and timeout coincide, ack wins (err=0).
- Response latency:
  - Minimum request-to-done is 3 edges: accept, ack seen in the first WAIT cycle, done.
  - The done cycle is IDLE, so a new request can be sampled in it; back-to-back grants are therefore 2 cycles apart minimum.
- Boundary rules:
  - rdata and err of the non-winning master keep their previous values.
  - Requests arriving during WAIT are not acknowledged until a later IDLE sample.
  - sl_ack outside WAIT is ignored.
  - A master dropping req before gnt simply withdraws; a master dropping req after gnt does not cancel the transaction.

Test Plan:
- Single read: m0_req, addr=0x00001004, we=0; slave acks in the 2nd WAIT cycle with 0xDEADBEEF -> m0_gnt pulse at edge+1, sl_addr=0x00001004, sl_req high for 2 cycles, m0_done with m0_rdata=0xDEADBEEF, m0_err=0, m1 outputs untouched.
- Tie, CPU_PRIORITY=1, STARVE_LIMIT=4; both masters request continuously; slave acks immediately -> grant order m0,m0,m0,m0,m1,m0,... with m1_gnt on the 5th grant and starve_cnt back to 0.
- Tie, CPU_PRIORITY=0, both requesting continuously -> grants alternate m0,m1,m0,m1; consecutive gnt pulses are 2 cycles apart.
- Timeout, TIMEOUT=16: m1 write, we=4'b0011, wdata=0x0000ABCD; slave never acks -> sl_req high exactly 16 cycles, then m1_done=1, m1_err=1, m1_rdata=0, busy=0.
- Ack on the same cycle as timeout -> done with err=0 and rdata=sl_rdata; a stray sl_ack during IDLE produces no done pulse.
- Reset pulled low in the 3rd WAIT cycle -> sl_req, busy and all gnt/done outputs go 0 immediately; after release, m0 wins the first tie.
